// File: rtl/sram_axi_slave_if.sv
// ============================================================================
// sram_axi_slave_if : AXI4 bus bundle between an AXI master and sram_axi_slave
// Rev 1.0
// ============================================================================
`default_nettype none

interface sram_axi_slave_if #(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     awid;
   logic [31:0]         awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   logic [ID_W-1:0]     arid;
   logic [31:0]         araddr;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;

   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

`default_nettype wire

// File: rtl/sram_axi_slave.sv
// ============================================================================
// sram_axi_slave : AXI4 INCR-burst slave onto a single-port sync SRAM
// Optional SLVERR checking on non-INCR / non-32-bit bursts: SRAM_AXI_ERR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_axi_slave #(
   parameter int ID_W    = 8,
   parameter int DATA_W  = 32,
   parameter int SRAM_AW = 14
) (
   input  logic                clk,
   input  logic                rst,
   sram_axi_slave_if.slave     s_axi,
   output logic                o_ceb,
   output logic                o_web,
   output logic [DATA_W-1:0]   o_bweb,
   output logic [SRAM_AW-1:0]  o_a,
   output logic [DATA_W-1:0]   o_di,
   input  logic [DATA_W-1:0]   i_do
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_R_RD   = 3'd1,
      S_R_DATA = 3'd2,
      S_W_DATA = 3'd3,
      S_W_RESP = 3'd4
   } state_t;

   localparam logic       c_PRIO_READ  = 1'b0;
   localparam logic       c_PRIO_WRITE = 1'b1;
   localparam logic [1:0] c_RESP_OKAY  = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;

   state_t               r_state;
   logic                 r_prio;
   logic [ID_W-1:0]      r_id;
   logic [3:0]           r_len;
   logic [3:0]           r_cnt;
   logic [SRAM_AW-1:0]   r_addr;

   logic w_aw_grant;
   logic w_ar_grant;
   logic w_w_hs;
   logic w_rlast;
   logic w_err;
   logic w_sram_rd;
   logic w_sram_wr;

   assign w_aw_grant = rst && (r_state == S_IDLE) && s_axi.awvalid &&
                       (!s_axi.arvalid || (r_prio == c_PRIO_WRITE));
   assign w_ar_grant = rst && (r_state == S_IDLE) && s_axi.arvalid && !w_aw_grant;

`ifdef SRAM_AXI_ERR_EN
   logic r_err;
   logic w_err_aw;
   logic w_err_ar;

   assign w_err_aw = (s_axi.awburst != 2'b01) || (s_axi.awsize != 3'b010);
   assign w_err_ar = (s_axi.arburst != 2'b01) || (s_axi.arsize != 3'b010);

   // The flag lives for the whole burst; it is re-evaluated at every grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_aw_grant) begin
         r_err <= w_err_aw;
      end else if (w_ar_grant) begin
         r_err <= w_err_ar;
      end
   end

   assign w_err = r_err;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst};
   assign w_err        = 1'b0;
`endif

   logic w_unused_addr;
   assign w_unused_addr = ^{s_axi.awaddr[31:SRAM_AW+2], s_axi.awaddr[1:0],
                            s_axi.araddr[31:SRAM_AW+2], s_axi.araddr[1:0]};

   // Bus-side outputs decode the registered state; readies are gated by rst
   assign s_axi.awready = w_aw_grant;
   assign s_axi.arready = w_ar_grant;
   assign s_axi.wready  = rst && (r_state == S_W_DATA);
   assign w_w_hs        = s_axi.wready && s_axi.wvalid;

   assign w_rlast       = (r_cnt == r_len);
   assign s_axi.rvalid  = (r_state == S_R_DATA);
   assign s_axi.rid     = r_id;
   assign s_axi.rdata   = w_err ? '0 : i_do;
   assign s_axi.rresp   = w_err ? c_RESP_SLVERR : c_RESP_OKAY;
   assign s_axi.rlast   = w_rlast;

   assign s_axi.bvalid  = (r_state == S_W_RESP);
   assign s_axi.bid     = r_id;
   assign s_axi.bresp   = w_err ? c_RESP_SLVERR : c_RESP_OKAY;

   // SRAM controls: the write path is combinational on WVALID for 1 beat/cycle
   assign w_sram_rd = (r_state == S_R_RD) && !w_err;
   assign w_sram_wr = w_w_hs && !w_err;
   assign o_ceb     = !(w_sram_rd || w_sram_wr);
   assign o_web     = !w_sram_wr;
   assign o_a       = (w_sram_rd || w_sram_wr) ? r_addr : '0;
   assign o_di      = w_sram_wr ? s_axi.wdata : '0;

   for (genvar i = 0; i < DATA_W / 8; i++) begin : g_bweb
      assign o_bweb[8*i +: 8] = w_sram_wr ? {8{~s_axi.wstrb[i]}} : 8'hFF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_prio  <= c_PRIO_READ;
         r_id    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_aw_grant) begin
                  r_id    <= s_axi.awid;
                  r_len   <= s_axi.awlen;
                  r_addr  <= s_axi.awaddr[SRAM_AW+1:2];
                  r_cnt   <= '0;
                  r_state <= S_W_DATA;
               end else if (w_ar_grant) begin
                  r_id    <= s_axi.arid;
                  r_len   <= s_axi.arlen;
                  r_addr  <= s_axi.araddr[SRAM_AW+1:2];
                  r_cnt   <= '0;
                  r_state <= S_R_RD;
               end
            end
            S_R_RD: begin
               r_state <= S_R_DATA;
            end
            S_R_DATA: begin
               if (s_axi.rready) begin
                  if (w_rlast) begin
                     r_prio  <= c_PRIO_WRITE;
                     r_state <= S_IDLE;
                  end else begin
                     r_addr  <= r_addr + 1'b1;
                     r_cnt   <= r_cnt + 4'd1;
                     r_state <= S_R_RD;
                  end
               end
            end
            S_W_DATA: begin
               // WLAST ends the burst regardless of the latched length
               if (s_axi.wvalid) begin
                  r_addr <= r_addr + 1'b1;
                  if (s_axi.wlast) begin
                     r_state <= S_W_RESP;
                  end
               end
            end
            S_W_RESP: begin
               if (s_axi.bready) begin
                  r_prio  <= c_PRIO_READ;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_axi_slave.sv
// ============================================================================
// tb_sram_axi_slave : scoreboard bench for sram_axi_slave with a sync SRAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_axi_slave;

`ifdef SRAM_AXI_ERR_EN
   localparam bit c_ERR_EN = 1'b1;
`else
   localparam bit c_ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
   } bexp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ceb, web;
   logic [31:0] bweb, di, dout;
   logic [13:0] a;

   logic [31:0] sram    [0:16383];
   logic [31:0] ref_mem [0:16383];
   logic        init_done = 1'b0;

   rexp_t rq[$];
   bexp_t bq[$];
   logic  grant_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   sram_axi_slave_if #(.ID_W(8), .DATA_W(32)) bus ();

   sram_axi_slave #(.ID_W(8), .DATA_W(32), .SRAM_AW(14)) dut (
      .clk    (clk),
      .rst    (rst),
      .s_axi  (bus),
      .o_ceb  (ceb),
      .o_web  (web),
      .o_bweb (bweb),
      .o_a    (a),
      .o_di   (di),
      .i_do   (dout)
   );

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1);
   endfunction

   function automatic logic err_of(input logic [1:0] burst);
      return c_ERR_EN && (burst != 2'b01);
   endfunction

   // Synchronous SRAM: one-cycle read latency, output held while deselected
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 16384; i++) sram[i] <= pat(i);
         init_done <= 1'b1;
      end else if (!ceb) begin
         if (!web) sram[a] <= (sram[a] & bweb) | (di & ~bweb);
         else      dout    <= sram[a];
      end
   end

   task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n,
                           output int cycles);
      logic [13:0] w;
      logic        e;
      rexp_t       ex;
      int          n, g;
      logic [31:0] hd;
      logic        hl;
      w = addr[15:2];
      e = err_of(burst);
      cycles = -1;
      for (int i = 0; i <= len; i++)
         rq.push_back('{id: id, data: (e ? 32'h0 : ref_mem[14'(w + i)]),
                        resp: (e ? 2'b10 : 2'b00), last: (i == len)});
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len); bus.arsize = 3'b010;
      bus.arburst = burst; bus.arvalid = 1'b1; bus.rready = 1'b1;
      #1; g = 0;
      while (!bus.arready && g < 100) begin @(negedge clk); #1; g++; end
      n_chk++;
      if (bus.arready !== 1'b1) begin
         n_fail++; $display("FAIL ar_accept: arready=%b required 1", bus.arready);
         bus.arvalid = 1'b0; rq.delete(); return;
      end
      grant_q.push_back(1'b0);
      n_chk++;
      if (bus.awready !== 1'b0) begin
         n_fail++; $display("FAIL ready_exclusive: awready=%b required 0 with arready", bus.awready);
      end
      @(negedge clk); bus.arvalid = 1'b0; n = 1; #1;
      n_chk++;
      if ({ceb, web, a} !== {e, 1'b1, (e ? 14'h0 : w)}) begin
         n_fail++; $display("FAIL rd_access: ceb=%b web=%b a=%h required ceb=%b web=1 a=%h",
                            ceb, web, a, e, (e ? 14'h0 : w));
      end
      for (int b = 0; b <= len; b++) begin
         g = 0;
         do begin @(negedge clk); n++; #1; g++; end while (!bus.rvalid && g < 20);
         n_chk++;
         if (bus.rvalid !== 1'b1) begin
            n_fail++; $display("FAIL r_valid: rvalid=%b required 1 on beat %0d", bus.rvalid, b);
            rq.delete(); return;
         end
         if (b == stall_beat) begin
            bus.rready = 1'b0; hd = bus.rdata; hl = bus.rlast;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk); n++; #1;
               n_chk++;
               if ({bus.rvalid, bus.rdata, bus.rlast} !== {1'b1, hd, hl}) begin
                  n_fail++; $display("FAIL r_stall: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                                     bus.rvalid, bus.rdata, bus.rlast, hd, hl);
               end
            end
            bus.rready = 1'b1;
         end
         ex = rq.pop_front();
         n_chk++;
         if ({bus.rid, bus.rdata, bus.rresp, bus.rlast} !== ex) begin
            n_fail++; $display("FAIL r_beat%0d: id=%h data=%h resp=%b last=%b required id=%h data=%h resp=%b last=%b",
                               b, bus.rid, bus.rdata, bus.rresp, bus.rlast, ex.id, ex.data, ex.resp, ex.last);
         end
      end
      cycles = n;
   endtask

   task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int strb_beat, input logic [3:0] strb_val,
                            input logic [31:0] seed);
      logic [13:0] w, wa;
      logic        e;
      logic [31:0] data, xbweb;
      logic [3:0]  strb;
      bexp_t       bx;
      int          g;
      w = addr[15:2];
      e = err_of(burst);
      @(negedge clk);
      bus.bready = 1'b0;
      bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len); bus.awsize = 3'b010;
      bus.awburst = burst; bus.awvalid = 1'b1;
      #1; g = 0;
      while (!bus.awready && g < 100) begin @(negedge clk); #1; g++; end
      n_chk++;
      if (bus.awready !== 1'b1) begin
         n_fail++; $display("FAIL aw_accept: awready=%b required 1", bus.awready);
         bus.awvalid = 1'b0; return;
      end
      grant_q.push_back(1'b1);
      n_chk++;
      if (bus.arready !== 1'b0) begin
         n_fail++; $display("FAIL ready_exclusive: arready=%b required 0 with awready", bus.arready);
      end
      @(negedge clk); bus.awvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         data  = seed + 32'(b) * 32'h11111111;
         strb  = (b == strb_beat) ? strb_val : 4'hF;
         wa    = 14'(w + b);
         xbweb = ~{{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
         bus.wdata = data; bus.wstrb = strb; bus.wlast = (b == len); bus.wvalid = 1'b1;
         #1;
         n_chk++;
         if ({bus.wready, ceb, web, a, di, bweb} !==
             (e ? {1'b1, 1'b1, 1'b1, 14'h0, 32'h0, 32'hFFFFFFFF}
                : {1'b1, 1'b0, 1'b0, wa, data, xbweb})) begin
            n_fail++; $display("FAIL w_beat%0d: wready=%b ceb=%b web=%b a=%h di=%h bweb=%h required a=%h di=%h bweb=%h err=%b",
                               b, bus.wready, ceb, web, a, di, bweb, wa, data, xbweb, e);
         end
         if (!e)
            for (int l = 0; l < 4; l++)
               if (strb[l]) ref_mem[wa][8*l +: 8] = data[8*l +: 8];
         @(negedge clk);
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      bq.push_back('{id: id, resp: (e ? 2'b10 : 2'b00)});
      #1;
      n_chk++;
      if (bus.bvalid !== 1'b1) begin
         n_fail++; $display("FAIL b_valid: bvalid=%b required 1 after WLAST", bus.bvalid);
      end
      @(negedge clk); #1;
      n_chk++;
      if (bus.bvalid !== 1'b1) begin
         n_fail++; $display("FAIL b_hold: bvalid=%b required 1 while bready=0", bus.bvalid);
      end
      bus.bready = 1'b1;
      bx = bq.pop_front();
      n_chk++;
      if ({bus.bid, bus.bresp} !== bx) begin
         n_fail++; $display("FAIL b_resp: bid=%h bresp=%b required bid=%h bresp=%b",
                            bus.bid, bus.bresp, bx.id, bx.resp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.awvalid = 1'b1; bus.arvalid = 1'b1; bus.wvalid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({bus.awready, bus.arready, bus.wready} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ready: aw/ar/w ready=%b%b%b required 000",
                            bus.awready, bus.arready, bus.wready);
      end
      n_chk++;
      if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_valid: bvalid=%b rvalid=%b required 0 0", bus.bvalid, bus.rvalid);
      end
      n_chk++;
      if ({ceb, web, bweb, a} !== {1'b1, 1'b1, 32'hFFFFFFFF, 14'h0}) begin
         n_fail++; $display("FAIL reset_sram: ceb=%b web=%b bweb=%h a=%h required 1 1 ffffffff 0000",
                            ceb, web, bweb, a);
      end
      @(negedge clk);
      bus.awvalid = 1'b0; bus.arvalid = 1'b0; bus.wvalid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      int cyc;
      axi_read(8'h11, 32'h10, 0, 2'b01, -1, 0, cyc);
      n_chk++;
      if (cyc !== 2) begin
         n_fail++; $display("FAIL single_read_latency: cycles=%0d required 2", cyc);
      end
   endtask

   task automatic test_write_readback();
      int cyc;
      axi_write(8'h22, 32'h20, 3, 2'b01, 2, 4'b0011, 32'h12345678);
      n_chk++;
      if (sram[10][31:16] !== pat(10)[31:16]) begin
         n_fail++; $display("FAIL strobe_keep: upper half=%h required %h", sram[10][31:16], pat(10)[31:16]);
      end
      axi_read(8'h23, 32'h20, 3, 2'b01, -1, 0, cyc);
      n_chk++;
      if (cyc !== 8) begin
         n_fail++; $display("FAIL burst4_latency: cycles=%0d required 8", cyc);
      end
   endtask

   task automatic test_arbitration();
      int c1, c2;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      grant_q.delete();
      fork
         begin
            axi_read(8'h31, 32'h80, 0, 2'b01, -1, 0, c1);
            axi_read(8'h32, 32'h90, 0, 2'b01, -1, 0, c2);
         end
         axi_write(8'h41, 32'h40, 0, 2'b01, -1, 4'hF, 32'hA1B2C3D4);
      join
      n_chk++;
      if (grant_q.size() != 3 || grant_q[0] !== 1'b0 || grant_q[1] !== 1'b1 || grant_q[2] !== 1'b0) begin
         n_fail++; $display("FAIL arb_order: %0d grants (first=%b second=%b) required R,W,R",
                            grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : 1'bx,
                            (grant_q.size() > 1) ? grant_q[1] : 1'bx);
      end
   endtask

   task automatic test_read_stall();
      int cyc;
      axi_read(8'h33, 32'h200, 3, 2'b01, 1, 5, cyc);
      n_chk++;
      if (cyc !== 13) begin
         n_fail++; $display("FAIL stall_latency: cycles=%0d required 13", cyc);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      axi_write(8'h44, 32'h0000FFFC, 1, 2'b01, -1, 4'hF, 32'h5EED0001);
      axi_read(8'h45, 32'h0000FFFC, 1, 2'b01, -1, 0, cyc);
      axi_read(8'h46, 32'h0, 0, 2'b01, -1, 0, cyc);
   endtask

   task automatic test_burst_type();
      int cyc;
      axi_read(8'h55, 32'h300, 2, 2'b10, -1, 0, cyc);
      n_chk++;
      if (cyc !== 6) begin
         n_fail++; $display("FAIL wrap_burst_latency: cycles=%0d required 6", cyc);
      end
      axi_write(8'h56, 32'h400, 1, 2'b00, -1, 4'hF, 32'hDEAD0000);
      axi_read(8'h57, 32'h400, 1, 2'b01, -1, 0, cyc);
   endtask

   task automatic test_reset_midburst();
      int g, cyc;
      @(negedge clk);
      bus.bready = 1'b0;
      bus.awid = 8'h61; bus.awaddr = 32'h100; bus.awlen = 4'd3; bus.awsize = 3'b010;
      bus.awburst = 2'b01; bus.awvalid = 1'b1;
      #1; g = 0;
      while (!bus.awready && g < 20) begin @(negedge clk); #1; g++; end
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wdata = 32'hFACE0000; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      ref_mem[14'h40] = 32'hFACE0000;
      @(negedge clk);
      bus.wdata = 32'hFACE1111; #1;
      n_chk++;
      if ({ceb, a} !== {1'b0, 14'h41}) begin
         n_fail++; $display("FAIL midburst_active: ceb=%b a=%h required 0 0041", ceb, a);
      end
      rst = 1'b0; #1;
      n_chk++;
      if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, ceb, web, bweb, a} !==
          {5'b00000, 1'b1, 1'b1, 32'hFFFFFFFF, 14'h0}) begin
         n_fail++; $display("FAIL midburst_reset: rdy=%b%b%b bv=%b rv=%b ceb=%b web=%b bweb=%h a=%h required reset levels",
                            bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, ceb, web, bweb, a);
      end
      @(negedge clk);
      bus.wvalid = 1'b0; rst = 1'b1;
      axi_read(8'h62, 32'h100, 1, 2'b01, -1, 0, cyc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i);
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
      bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010;
      bus.arburst = 2'b01; bus.arvalid = 1'b0; bus.rready = 1'b0;
      test_reset();
      test_single_read();
      test_write_readback();
      test_arbitration();
      test_read_stall();
      test_wrap();
      test_burst_type();
      test_reset_midburst();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
